seq_detector: RTL and testbench
===============================

# seq_detector

Serial bit-pattern detector. Samples a single-bit input stream `a_i` on every rising clock edge and compares the most recent `PAT_LEN` samples against `PATTERN`. On a match it raises `flag_o` for one cycle. Overlapping occurrences are detected. It sits directly behind a serial input source, for example a keyboard or serial front end, and raises an event flag for downstream control logic.

## Interface
- `PAT_LEN`, default 4: pattern length in bits; legal range 2..16.
- `PATTERN`, default 4'b1001: target sequence. The MSB is the earliest-received bit and the LSB is the most recent.
- `clk_i`, input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n`, input, 1 bit: asynchronous, active-low reset.
- `a_i`, input, 1 bit: serial data bit, sampled every rising edge.
- `flag_o`, output, 1 bit: registered match flag; high for one cycle per detected occurrence.

## Operation
- State:
  - History shift register `hist[PAT_LEN-1:0]`.
  - Fill counter `fill`, saturating at `PAT_LEN`, of width $clog2(PAT_LEN+1).
  - Output register `flag_o`.
- Each rising edge with `rst_n` high:
  - `hist <= {hist[PAT_LEN-2:0], a_i}`.
  - `fill <= (fill == PAT_LEN) ? PAT_LEN : fill + 1`.
  - `flag_o <= (next_hist == PATTERN) && (next_fill == PAT_LEN)`, where next_* are the values being loaded this edge.
- The fill gating prevents false matches against reset-state history. No match is possible until `PAT_LEN` bits have been sampled since reset.
- Overlap: there is no history clear after a match. The next match may use bits of the previous one. Example: with PATTERN=1001, the stream 1001001 yields two pulses.
- FSM view: `fill` encodes states FILL_0..FILL_{PAT_LEN-1}, then RUN.
  - FILL_k advances to FILL_{k+1} on every edge.
  - RUN stays in RUN.
  - Reset returns to FILL_0 from any state.
- No enable and no clear input. Every edge consumes one bit.
- An X or Z on `a_i` is not handled. The driver must present known levels at every sampling edge.

## Timing
- Reset (`rst_n`=0), asynchronous and immediate: `hist`=0, `fill`=0, `flag_o`=0. Outputs hold these values while reset is asserted.
- Reset release: the first rising edge with `rst_n`=1 samples bit #1 of the stream.
- Latency: `flag_o` rises on the same edge that samples the last pattern bit. It is visible for exactly the following clock period.
- Pulse width:
  - 1 cycle per match.
  - Back-to-back matches (possible only for self-overlapping patterns such as all-ones) hold `flag_o` high for consecutive cycles, one cycle per match.
- Reset mid-stream: history and fill are discarded, and `flag_o` drops immediately. A partial pattern received before reset never completes a match after reset.
- Earliest possible flag: edge number `PAT_LEN` after reset release.

## Test plan
- Reset check: assert `rst_n`=0 mid-cycle with `flag_o` high -> `flag_o`=0 immediately, before the next edge; it stays 0 for the first 3 edges after release regardless of `a_i`.
- Directed stream, default params:
  - Stimulus: feed the bits of 16'b0000_0011_1111_1001 LSB-first, one per edge after release: 1,0,0,1,1,1,1,1,1,1,0,0,0,0,0,0.
  - Required response: exactly one pulse, with `flag_o`=1 only in the cycle after edge #4. It is 0 at all other times.
- Overlap: stream 1,0,0,1,0,0,1 -> pulses after edges #4 and #7 only.
- No-match stream: 16 zeros, then 16 ones -> `flag_o` stays 0 throughout.
- Reset mid-pattern: feed 1,0,0, pulse `rst_n` low, then feed 1,0,0,0 -> no pulse. Then feed 1,0,0,1 -> pulse after that sequence's 4th edge.
- Parameter variant, PAT_LEN=3 and PATTERN=3'b111: feed 5 consecutive ones -> `flag_o` high for 3 consecutive cycles, after edges #3, #4 and #5.

Source files
------------

// File: rtl/seq_detector_if.sv
// Serial bit-stream interface for the pattern detector.
//
// There is no flow control on this interface: the source presents a known
// level on a_i at every rising edge and the detector consumes exactly one bit
// per edge (implicitly always valid and always ready). flag_o is a registered,
// single-cycle event back to the consumer.
interface seq_detector_if;
  logic a_i;
  logic flag_o;

  // Source side: drives serial bits, observes the match flag.
  modport master (output a_i, input flag_o);

  // Detector side: samples serial bits, produces the match flag.
  modport slave (input a_i, output flag_o);
endinterface

// File: rtl/seq_detector.sv
// Serial bit-pattern detector.
// Shifts a_i into a PAT_LEN-bit history every rising edge and raises flag_o
// for one cycle whenever the newest PAT_LEN bits equal PATTERN (MSB = oldest
// bit). Overlapping occurrences are reported because history is never cleared
// on a match. A saturating fill counter blocks matches against the all-zero
// history left by reset until PAT_LEN real bits have been sampled.
module seq_detector #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1001
) (
  input  logic                           clk_i,
  input  logic                           rst_n,
  seq_detector_if.slave                  bus,
  output logic [$clog2(PAT_LEN+1)-1:0]   dbg_fill,
  output logic                           dbg_run
);

  localparam int             FW   = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0]  FULL = FW'(PAT_LEN);

  // Coarse phase of the detector: FILL while fill < PAT_LEN, RUN afterwards.
  // The fine-grained FILL_k position is the fill counter itself.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t               state;
  logic [PAT_LEN-1:0]   hist;
  logic [FW-1:0]        fill;
  logic                 flag_q;

  logic [PAT_LEN-1:0]   next_hist;
  logic [FW-1:0]        next_fill;

  // Values loaded on the coming edge; the match is judged on these so the
  // flag rises on the same edge that samples the last pattern bit.
  always_comb begin
    next_hist = {hist[PAT_LEN-2:0], bus.a_i};
    next_fill = (fill == FULL) ? FULL : fill + FW'(1);
  end

  // History, fill/phase state and registered match flag.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      hist   <= '0;
      fill   <= '0;
      state  <= ST_FILL;
      flag_q <= 1'b0;
    end else begin
      hist   <= next_hist;
      fill   <= next_fill;
      state  <= (next_fill == FULL) ? ST_RUN : ST_FILL;
      flag_q <= (next_hist == PATTERN) && (next_fill == FULL);
    end
  end

  assign bus.flag_o = flag_q;
  assign dbg_fill   = fill;
  assign dbg_run    = (state == ST_RUN);

endmodule

// File: tb/tb_seq_detector.sv
// Self-checking bench for seq_detector: a default instance (1001) and a
// PAT_LEN=3 / 111 instance. Inputs change on the falling edge; flag_o is
// compared on the following falling edge, one cycle after each bit is driven.
module tb_seq_detector;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_d = 1'b0;
  logic rst_v = 1'b0;
  always #5 clk_i = ~clk_i;

  seq_detector_if bus_d ();
  seq_detector_if bus_v ();

  logic [2:0] fill_d;
  logic       run_d;
  logic [1:0] fill_v;
  logic       run_v;

  seq_detector dut_d (
    .clk_i    (clk_i),
    .rst_n    (rst_d),
    .bus      (bus_d),
    .dbg_fill (fill_d),
    .dbg_run  (run_d)
  );

  seq_detector #(.PAT_LEN(3), .PATTERN(3'b111)) dut_v (
    .clk_i    (clk_i),
    .rst_n    (rst_v),
    .bus      (bus_v),
    .dbg_fill (fill_v),
    .dbg_run  (run_v)
  );

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int fails     = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge: drive one bit, push its expected flag, let one
  // rising edge sample it, then compare at the next falling edge.
  task automatic drive_bit(input bit sel_v, input logic a, input logic exp, input string name);
    logic [0:0] e;
    if (sel_v) bus_v.a_i = a;
    else       bus_d.a_i = a;
    exp_q.push_back(exp);
    @(posedge clk_i);
    @(negedge clk_i);
    if (exp_q.size() == 0) begin
      check({name, "_qempty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(name, sel_v ? bus_v.flag_o : bus_d.flag_o, e);
    end
  endtask

  // Called at a falling edge: assert reset mid-cycle, check the asynchronous
  // clear, release at the next falling edge.
  task automatic do_reset(input bit sel_v);
    if (sel_v) rst_v = 1'b0;
    else       rst_d = 1'b0;
    #1;
    if (sel_v) begin
      check("rst_flag_v", bus_v.flag_o, 1'b0);
      check("rst_fill_v", fill_v, 2'd0);
      check("rst_run_v", run_v, 1'b0);
    end else begin
      check("rst_flag_d", bus_d.flag_o, 1'b0);
      check("rst_fill_d", fill_d, 3'd0);
      check("rst_run_d", run_d, 1'b0);
    end
    @(negedge clk_i);
    if (sel_v) rst_v = 1'b1;
    else       rst_d = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit   rst_before;
    logic a;
    logic exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit r, input logic a, input logic e);
    vec_t v;
    v.rst_before = r;
    v.a          = a;
    v.exp        = e;
    vecs.push_back(v);
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [15:0] dir_stream;
    logic [6:0]  ov_stream;
    logic [7:0]  mid_stream;
    logic [0:0]  rb;

    bus_d.a_i = 1'b0;
    bus_v.a_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Reset state while held in reset
    check("init_flag_d", bus_d.flag_o, 1'b0);
    check("init_fill_d", fill_d, 3'd0);
    check("init_flag_v", bus_v.flag_o, 1'b0);

    // Directed stream, LSB first: single pulse after edge 4
    dir_stream = 16'b0000_0011_1111_1001;
    for (int i = 0; i < 16; i++) add(i == 0, dir_stream[i], i == 3);

    // Overlap: 1001001 -> pulses after edges 4 and 7
    ov_stream = 7'b1001001;
    for (int i = 0; i < 7; i++) add(i == 0, ov_stream[6-i], (i == 3) || (i == 6));

    // No match: 16 zeros then 16 ones
    for (int i = 0; i < 32; i++) add(i == 0, (i >= 16), 1'b0);

    // Reset mid-pattern: 1,0,0 | reset | 1,0,0,0,1,0,0,1 -> pulse on the last
    add(1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0);
    mid_stream = 8'b1000_1001;
    for (int i = 0; i < 8; i++) add(i == 0, mid_stream[7-i], i == 7);

    foreach (vecs[i]) begin
      if (vecs[i].rst_before) do_reset(1'b0);
      drive_bit(1'b0, vecs[i].a, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Hand-written: reset while flag_o is high, then 3 arbitrary bits stay quiet
    do_reset(1'b0);
    drive_bit(1'b0, 1'b1, 1'b0, "hi_b1");
    drive_bit(1'b0, 1'b0, 1'b0, "hi_b2");
    drive_bit(1'b0, 1'b0, 1'b0, "hi_b3");
    drive_bit(1'b0, 1'b1, 1'b1, "hi_b4");
    check("hi_fill_sat", fill_d, 3'd4);
    check("hi_run", run_d, 1'b1);
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      rb = 1'($urandom_range(0, 1));
      drive_bit(1'b0, rb, 1'b0, $sformatf("post_rst_b%0d", i + 1));
    end
    check("post_rst_fill", fill_d, 3'd3);

    // Hand-written: PAT_LEN=3, 111, five ones -> three back-to-back pulses
    do_reset(1'b1);
    drive_bit(1'b1, 1'b1, 1'b0, "v_b1");
    drive_bit(1'b1, 1'b1, 1'b0, "v_b2");
    drive_bit(1'b1, 1'b1, 1'b1, "v_b3");
    drive_bit(1'b1, 1'b1, 1'b1, "v_b4");
    drive_bit(1'b1, 1'b1, 1'b1, "v_b5");
    drive_bit(1'b1, 1'b0, 1'b0, "v_b6");
    check("v_fill_sat", fill_v, 2'd3);

    // Final report
    if (exp_q.size() != 0) check("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
